// File: rtl/yd_int_req.sv
// Interrupt request generator: edge-detects up to 8 sources into PEND, masks and
// arbitrates by fixed priority, and issues one int_vld pulse per interrupt until EOI.
module yd_int_req #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq_in,
  output logic         int_vld,
  input  logic         int_rdy,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [15:0]  cfg_wdata,
  output logic [15:0]  cfg_rdata,
  output logic         irq_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, ACKLO, ACKHI, SVC} state_t;

  localparam logic [1:0] ADDR_PEND  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_CAUSE = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  state_t       state, state_next;
  logic [1:0]   ack_cnt, ack_cnt_next;
  logic [N-1:0] irq_prev, pend, pend_next, mask;
  logic [N-1:0] edges, eligible;
  logic [2:0]   winner, cause_id;
  logic         cause_vld, gen, err;
  logic         issue, timeout;
  logic         wr_pend, wr_mask, wr_cause, wr_ctrl;

  assign edges    = irq_in & ~irq_prev;
  assign eligible = pend & mask;
  assign irq_busy = (state != IDLE);

  assign wr_pend  = cfg_we && (cfg_addr == ADDR_PEND);
  assign wr_mask  = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_cause = cfg_we && (cfg_addr == ADDR_CAUSE);
  assign wr_ctrl  = cfg_we && (cfg_addr == ADDR_CTRL);

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    ack_cnt_next = ack_cnt;
    issue        = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (gen && |eligible && int_rdy && !cause_vld) begin
          issue      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ack_cnt_next = '0;
        state_next   = ACKLO;
      end
      ACKLO: begin
        if (!int_rdy) begin
          state_next = ACKHI;
        end else if (ack_cnt == 2'd2) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          ack_cnt_next = ack_cnt + 2'd1;
        end
      end
      ACKHI:   if (int_rdy) state_next = SVC;
      SVC:     if (!cause_vld) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // New edges are applied last so a set beats any clear landing on the same bit.
  always_comb begin
    pend_next = pend;
    if (wr_pend) pend_next = pend_next & ~cfg_wdata[N-1:0];
    if (issue)   pend_next = pend_next & ~(N'(1) << winner);
    if (timeout) pend_next = pend_next | (N'(1) << cause_id);
    pend_next = pend_next | edges;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ack_cnt <= '0;
    end else begin
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_prev  <= '0;
      pend      <= '0;
      mask      <= '0;
      gen       <= 1'b0;
      err       <= 1'b0;
      cause_vld <= 1'b0;
      cause_id  <= '0;
      int_vld   <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pend     <= pend_next;
      int_vld  <= issue;
      if (wr_mask) mask <= cfg_wdata[N-1:0];
      if (wr_ctrl) gen  <= cfg_wdata[0];
      if (timeout)                        err <= 1'b1;
      else if (wr_ctrl && cfg_wdata[1])   err <= 1'b0;
      // A new issue only happens with CAUSE[15] already clear, so an EOI on that edge is moot.
      if (issue) begin
        cause_vld <= 1'b1;
        cause_id  <= winner;
      end else if (timeout || wr_cause) begin
        cause_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_PEND:  cfg_rdata = 16'(pend);
      ADDR_MASK:  cfg_rdata = 16'(mask);
      ADDR_CAUSE: cfg_rdata = {cause_vld, 12'd0, cause_id};
      default:    cfg_rdata = {14'd0, err, gen};
    endcase
  end

endmodule
